// File: rtl/seg8_lane_arbiter.sv
// seg8_lane_arbiter
// Round-robin arbiter sharing one seg8_indexer among NREQ activation lanes.
// Lanes present FP16 operands with valid/ready. At most one operand per cycle
// is issued to the indexer. A lane-ID tag travels beside each operand through
// the indexer latency, so every segment result is routed back to its lane.
// Optional build macro SEG8_ARB_RANGE_CHK_EN: flags operands outside 0 <= f < 1
// and replaces their segment with 0 (negative) or 7 (>= 1.0).

module seg8_lane_arbiter #(
    parameter int DW   = 16,
    parameter int NREQ = 4,
    parameter int LAT  = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_f_i,
    output logic [NREQ-1:0]    req_ready_o,
    input  logic               hold_i,
    output logic               idx_valid_o,
    output logic [DW-1:0]      idx_f_o,
    input  logic               idx_valid_i,
    input  logic [2:0]         idx_seg_i,
    output logic [NREQ-1:0]    rsp_valid_o,
    output logic [2:0]         rsp_seg_o,
    output logic               rsp_err_o,
    output logic               busy_o,
    output logic               proto_err_o
);

    localparam int IDW = $clog2(NREQ);

    // Round-robin pointer: first lane considered for the next grant
    logic [IDW-1:0] rr_ptr;

    // Grant selection
    logic           hit_hi;
    logic           hit_lo;
    logic [IDW-1:0] idx_hi;
    logic [IDW-1:0] idx_lo;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [DW-1:0]  gnt_f;
    logic           hs;

    // Range check result for the granted operand
    logic           chk_err;
    logic           chk_hi;

    // Tag travelling with the operand in the issue register
    logic [IDW-1:0] iss_id;
    logic           iss_err;
    logic           iss_hi;

    // Tag pipe, entry LAT-1 is the tag the indexer result must match
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_err;
    logic [LAT-1:0] tag_hi;
    logic [IDW-1:0] tag_id [LAT];

    logic           tail_v;
    logic           tail_err;
    logic           tail_hi;
    logic [IDW-1:0] tail_id;

    assign tail_v   = tag_v[LAT-1];
    assign tail_err = tag_err[LAT-1];
    assign tail_hi  = tag_hi[LAT-1];
    assign tail_id  = tag_id[LAT-1];

    // Pick the lowest requesting lane at or above rr_ptr, else wrap to the lowest requesting lane
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!hit_hi && req_valid_i[k] && (IDW'(k) >= rr_ptr)) begin
                hit_hi = 1'b1;
                idx_hi = IDW'(k);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!hit_lo && req_valid_i[k]) begin
                hit_lo = 1'b1;
                idx_lo = IDW'(k);
            end
        end
        gnt_found = hit_hi | hit_lo;
        gnt_idx   = hit_hi ? idx_hi : idx_lo;
    end

    // One-hot ready, suppressed while holding, and operand mux for the granted lane
    always_comb begin
        req_ready_o = '0;
        gnt_f       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == gnt_idx) begin
                req_ready_o[k] = gnt_found && !hold_i;
                gnt_f          = req_f_i[k*DW +: DW];
            end
        end
    end

    assign hs = gnt_found && !hold_i;

`ifdef SEG8_ARB_RANGE_CHK_EN
    // Flag operands the indexer cannot map: negative, or magnitude >= 1.0 (incl. inf/NaN)
    always_comb begin
        chk_err = gnt_f[DW-1] | (gnt_f[DW-2:0] >= 15'h3C00);
        chk_hi  = !gnt_f[DW-1] && (gnt_f[DW-2:0] >= 15'h3C00);
    end
`else
    // No range check: tags never carry an error
    always_comb begin
        chk_err = 1'b0;
        chk_hi  = 1'b0;
    end
`endif

    // Advance the round-robin pointer past the lane that just handshook
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (hs) begin
            rr_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Issue register towards the shared indexer; operand holds when idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_valid_o <= 1'b0;
            idx_f_o     <= '0;
            iss_id      <= '0;
            iss_err     <= 1'b0;
            iss_hi      <= 1'b0;
        end else begin
            idx_valid_o <= hs;
            iss_id      <= gnt_idx;
            iss_err     <= chk_err;
            iss_hi      <= chk_hi;
            if (hs) begin
                idx_f_o <= gnt_f;
            end
        end
    end

    // Tag pipe loaded from the issue register so its tail lines up with idx_valid_i
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v   <= '0;
            tag_err <= '0;
            tag_hi  <= '0;
            for (int unsigned i = 0; i < LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[0]   <= idx_valid_o;
            tag_err[0] <= iss_err;
            tag_hi[0]  <= iss_hi;
            tag_id[0]  <= iss_id;
            for (int unsigned i = 1; i < LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_err[i] <= tag_err[i-1];
                tag_hi[i]  <= tag_hi[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    // Route a matched result to its lane; any result/tag disagreement is a sticky protocol error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_o <= '0;
            rsp_seg_o   <= '0;
            rsp_err_o   <= 1'b0;
            proto_err_o <= 1'b0;
        end else begin
            if (idx_valid_i && tail_v) begin
                for (int unsigned k = 0; k < NREQ; k++) begin
                    rsp_valid_o[k] <= (IDW'(k) == tail_id);
                end
                rsp_seg_o <= tail_err ? (tail_hi ? 3'd7 : 3'd0) : idx_seg_i;
                rsp_err_o <= tail_err;
            end else begin
                rsp_valid_o <= '0;
            end
            if (idx_valid_i != tail_v) begin
                proto_err_o <= 1'b1;
            end
        end
    end

    assign busy_o = (|tag_v) | idx_valid_o | (|rsp_valid_o);

endmodule

// File: tb/tb_seg8_lane_arbiter.sv
// Testbench for seg8_lane_arbiter (LAT=1, NREQ=4).
// The bench plays the shared indexer and keeps its own reference model:
// a round-robin pointer, a queue of expected responses with due cycles,
// and real-valued segment computation (segment = count of k/8 thresholds <= f).

module tb_seg8_lane_arbiter;

    localparam int DW   = 16;
    localparam int NREQ = 4;
    localparam int LAT  = 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NREQ-1:0]    req_valid_i;
    logic [NREQ*DW-1:0] req_f_i;
    logic [NREQ-1:0]    req_ready_o;
    logic               hold_i;
    logic               idx_valid_o;
    logic [DW-1:0]      idx_f_o;
    logic               idx_valid_i;
    logic [2:0]         idx_seg_i;
    logic [NREQ-1:0]    rsp_valid_o;
    logic [2:0]         rsp_seg_o;
    logic               rsp_err_o;
    logic               busy_o;
    logic               proto_err_o;

    always #5 clk = ~clk;

    seg8_lane_arbiter #(.DW(DW), .NREQ(NREQ), .LAT(LAT)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid_i),
        .req_f_i     (req_f_i),
        .req_ready_o (req_ready_o),
        .hold_i      (hold_i),
        .idx_valid_o (idx_valid_o),
        .idx_f_o     (idx_f_o),
        .idx_valid_i (idx_valid_i),
        .idx_seg_i   (idx_seg_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_seg_o   (rsp_seg_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    typedef struct {
        int          lane;
        logic [15:0] f;
        int          due;
        bit          drop;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 4;
    int          mptr  = 0;
    bit          mproto = 1'b0;
    logic [NREQ-1:0] rv;
    logic [15:0] rf [NREQ];
    bit          hold;
    logic [15:0] last_f;
    bit          exp_iss_v;
    bit          iss_drop;
    bit          drop_req;
    bit          inj_req;
    int          inj_due = -1;
    bit          pend_v;
    logic [2:0]  pend_seg;
    bit          hs_log [4096];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Indexer stand-in: floor(f*8) via integer shifts; fixed junk values out of range
    function automatic logic [2:0] env_seg(input logic [15:0] f);
        logic [10:0] mant;
        int          ex;
        if (f[15]) return 3'd5;
        if (f[14:0] >= 15'h3C00) return 3'd2;
        ex = int'(f[14:10]);
        if (ex == 0) return 3'd0;
        mant = {1'b1, f[9:0]};
        return 3'(mant >> (22 - ex));
    endfunction

    // Reference expectation for one response
    task automatic ref_rsp(input logic [15:0] f, output logic [2:0] s, output logic e);
        real v;
        int  ex;
        s = 3'd0;
        e = 1'b0;
        if (f[15]) begin
`ifdef SEG8_ARB_RANGE_CHK_EN
            s = 3'd0; e = 1'b1;
`else
            s = 3'd5;
`endif
        end else if (f[14:0] >= 15'h3C00) begin
`ifdef SEG8_ARB_RANGE_CHK_EN
            s = 3'd7; e = 1'b1;
`else
            s = 3'd2;
`endif
        end else begin
            ex = int'(f[14:10]);
            if (ex == 0) v = real'(f[9:0]) * (2.0 ** (-24));
            else         v = real'(1024 + int'(f[9:0])) * (2.0 ** (ex - 25));
            for (int k = 1; k < 8; k++) begin
                if (v >= real'(k) / 8.0) s = 3'(k);
            end
        end
    endtask

    function automatic logic [15:0] rnd_f();
        logic [15:0] f;
        if ($urandom_range(0, 7) == 0) f = 16'($urandom);
        else f = {1'b0, 5'($urandom_range(0, 14)), 10'($urandom)};
        return f;
    endfunction

    task automatic step();
        int               g;
        logic [NREQ-1:0]  er;
        logic [NREQ-1:0]  erv;
        logic [NREQ*DW-1:0] pk;
        exp_t             e;
        logic [2:0]       es;
        logic             ee;
        bit               busy_exp;
        g = -1;
        if (!hold) begin
            for (int i = 0; i < NREQ; i++) begin
                if (g < 0 && rv[(mptr + i) % NREQ]) g = (mptr + i) % NREQ;
            end
        end
        for (int i = 0; i < NREQ; i++) pk[i*DW +: DW] = rf[i];
        req_valid_i = rv;
        req_f_i     = pk;
        hold_i      = hold;
        #1;
        er = (g >= 0) ? (NREQ'(1) << g) : '0;
        chk("grant", req_ready_o, er);
        exp_iss_v = 1'b0;
        if (g >= 0) begin
            mptr   = (g + 1) % NREQ;
            e.lane = g;
            e.f    = rf[g];
            e.due  = cyc + 3;
            e.drop = drop_req;
            q.push_back(e);
            hs_log[cyc] = 1'b1;
            exp_iss_v = 1'b1;
            last_f    = rf[g];
            iss_drop  = drop_req;
            drop_req  = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("iss_v", idx_valid_o, exp_iss_v);
        chk("iss_f", idx_f_o, last_f);
        erv = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.drop) begin
                mproto = 1'b1;
            end else begin
                erv = NREQ'(1) << e.lane;
                ref_rsp(e.f, es, ee);
                chk("rsp_seg", rsp_seg_o, es);
                chk("rsp_err", rsp_err_o, ee);
            end
        end
        if (cyc == inj_due) mproto = 1'b1;
        chk("rsp_v", rsp_valid_o, erv);
        busy_exp = hs_log[cyc-1] | hs_log[cyc-2] | (erv != '0);
        chk("busy", busy_o, busy_exp);
        chk("proto", proto_err_o, mproto);
        // indexer stand-in with one cycle of latency
        idx_valid_i = pend_v | inj_req;
        idx_seg_i   = pend_seg;
        if (inj_req) inj_due = cyc + 1;
        inj_req  = 1'b0;
        pend_v   = idx_valid_o & !iss_drop;
        pend_seg = env_seg(idx_f_o);
        iss_drop = 1'b0;
    endtask

    task automatic do_reset(input bit mid_op);
        rstn = 1'b0;
        #1;
        if (mid_op) begin
            chk("rst_async_rsp", rsp_valid_o, 4'b0000);
            chk("rst_async_iss", idx_valid_o, 1'b0);
            chk("rst_async_busy", busy_o, 1'b0);
        end
        rv = '0; hold = 1'b0;
        req_valid_i = '0; hold_i = 1'b0;
        idx_valid_i = 1'b0; idx_seg_i = '0;
        pend_v = 1'b0; pend_seg = '0;
        q.delete();
        mptr = 0; mproto = 1'b0; last_f = '0;
        inj_due = -1; iss_drop = 1'b0; drop_req = 1'b0; inj_req = 1'b0;
        for (int i = 0; i < 4096; i++) hs_log[i] = 1'b0;
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        rstn = 1'b1;
        chk("rst_ready", req_ready_o, 4'b0000);
        chk("rst_iss_v", idx_valid_o, 1'b0);
        chk("rst_iss_f", idx_f_o, 16'h0000);
        chk("rst_rsp_v", rsp_valid_o, 4'b0000);
        chk("rst_rsp_seg", rsp_seg_o, 3'd0);
        chk("rst_rsp_err", rsp_err_o, 1'b0);
        chk("rst_proto", proto_err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
    endtask

    initial begin
        rstn = 1'b1;
        rv = '0; hold = 1'b0;
        for (int i = 0; i < NREQ; i++) rf[i] = '0;
        req_valid_i = '0; req_f_i = '0; hold_i = 1'b0;
        idx_valid_i = 1'b0; idx_seg_i = '0;
        #1;
        do_reset(1'b0);

        // lane 2 alone, 0.125 -> segment 1 three cycles later
        rv = 4'b0100; rf[2] = 16'h3000;
        step();
        rv = '0;
        repeat (4) step();

        // all four lanes for eight cycles from a fresh pointer
        do_reset(1'b0);
        rv = 4'hF;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NREQ; i++) rf[i] = rnd_f();
            step();
        end
        rv = '0;
        repeat (4) step();

        // pointer moved to 2 by lane 1, then lanes 1 and 3 compete
        rv = 4'b0010; rf[1] = 16'h3400;
        step();
        rv = 4'b1010; rf[3] = 16'h3A00;
        step();
        step();
        rv = '0;
        repeat (4) step();

        // two tags in flight, then hold with all lanes requesting
        rv = 4'hF;
        for (int i = 0; i < NREQ; i++) rf[i] = rnd_f();
        step();
        step();
        hold = 1'b1;
        repeat (5) step();
        hold = 1'b0; rv = '0;
        step();

        // indexer swallows a result: tag dropped, protocol error
        rv = 4'b0001; rf[0] = 16'h3800; drop_req = 1'b1;
        step();
        rv = '0;
        repeat (4) step();

        // reset with tags in flight discards them
        rv = 4'hF;
        for (int i = 0; i < NREQ; i++) rf[i] = rnd_f();
        step();
        step();
        do_reset(1'b1);
        repeat (4) step();

        // out-of-range operands
        rv = 4'b0001; rf[0] = 16'h3C00;
        step();
        rv = 4'b0010; rf[1] = 16'hB800;
        step();
        rv = '0;
        repeat (4) step();

        // stray indexer result with nothing in flight
        inj_req = 1'b1;
        step();
        repeat (4) step();

        // random traffic
        do_reset(1'b0);
        for (int n = 0; n < 300; n++) begin
            rv   = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NREQ; i++) rf[i] = rnd_f();
            step();
        end
        rv = '0; hold = 1'b0;
        repeat (5) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
